// File: rtl/sd_init_sequencer_if.sv
// Command bus between the init sequencer and sd_controller.
// The master side issues commands and the slave side answers them.
interface sd_init_sequencer_if;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic [6:0]  crc;
  logic [2:0]  nresponse;
  logic        cmd_start;
  logic        cmd_done;
  logic [39:0] resp;

  modport master (
    output cmd, arg, crc, nresponse, cmd_start,
    input  cmd_done, resp
  );

  modport slave (
    input  cmd, arg, crc, nresponse, cmd_start,
    output cmd_done, resp
  );
endinterface

// File: rtl/sd_init_sequencer.sv
// SPI-mode SD card power-up sequencer: CMD0, CMD8, CMD55/ACMD41 loop, CMD58.
// Reports card version, capacity class, ready and error status.
module sd_init_sequencer #(
  parameter int unsigned CMD0_RETRIES   = 8,
  parameter int unsigned ACMD41_RETRIES = 1000,
  parameter int unsigned GAP_CYCLES     = 16,
  parameter int unsigned CMD_TIMEOUT    = 65535
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                init_start,
  output logic                busy,
  output logic                ready,
  output logic                error,
  output logic [2:0]          err_code,
  output logic                card_v2,
  output logic                card_sdhc,
  sd_init_sequencer_if.master bus
);

  localparam int unsigned C0W = $clog2(CMD0_RETRIES + 1);
  localparam int unsigned AW  = $clog2(ACMD41_RETRIES + 1);
  localparam int unsigned GW  = $clog2(GAP_CYCLES + 1);
  localparam int unsigned TW  = 16;

  typedef enum logic [2:0] {
    ST_IDLE, ST_CMD0, ST_CMD8, ST_CMD55, ST_CMD41, ST_CMD58, ST_DONE, ST_ERROR
  } state_t;

  state_t          state_q, state_d, issue_st;
  logic            await_q, await_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [C0W-1:0]  c0_q, c0_d;
  logic [AW-1:0]   pair_q, pair_d;
  logic            busy_q, busy_d, ready_q, ready_d, error_q, error_d;
  logic [2:0]      err_code_q, err_code_d;
  logic            v2_q, v2_d, sdhc_q, sdhc_d;
  logic [5:0]      cmd_q, cmd_d;
  logic [31:0]     arg_q, arg_d;
  logic [6:0]      crc_q, crc_d;
  logic [2:0]      nresp_q, nresp_d;
  logic            start_q, start_d;
  logic            issue, fail, finish_ok;
  logic [2:0]      fail_code;
  logic [7:0]      r1;
  logic            unused_resp;

  assign unused_resp = ^bus.resp[29:12];

  // Each command phase is a state; await_q splits it into gap-wait and response-wait.
  always_comb begin
    state_d    = state_q;
    await_d    = await_q;
    gap_d      = gap_q;
    tmo_d      = tmo_q;
    c0_d       = c0_q;
    pair_d     = pair_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    v2_d       = v2_q;
    sdhc_d     = sdhc_q;
    cmd_d      = cmd_q;
    arg_d      = arg_q;
    crc_d      = crc_q;
    nresp_d    = nresp_q;
    start_d    = 1'b0;
    issue      = 1'b0;
    issue_st   = state_q;
    fail       = 1'b0;
    fail_code  = 3'd0;
    finish_ok  = 1'b0;
    r1         = bus.resp[39:32];

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        state_d = ST_IDLE;
        if (init_start) begin
          ready_d    = 1'b0;
          error_d    = 1'b0;
          err_code_d = 3'd0;
          v2_d       = 1'b0;
          sdhc_d     = 1'b0;
          c0_d       = '0;
          pair_d     = '0;
          busy_d     = 1'b1;
          state_d    = ST_CMD0;
          issue      = 1'b1;
          issue_st   = ST_CMD0;
        end
      end
      default: begin
        if (!await_q) begin
          if (gap_q == GW'(GAP_CYCLES - 1)) issue = 1'b1;
          else                              gap_d = gap_q + GW'(1);
        end else if (bus.cmd_done) begin
          await_d = 1'b0;
          gap_d   = '0;
          case (state_q)
            ST_CMD0: begin
              if (r1 == 8'h01)                          state_d = ST_CMD8;
              else if (c0_q == C0W'(CMD0_RETRIES - 1)) begin fail = 1'b1; fail_code = 3'd1; end
              else                                      c0_d = c0_q + C0W'(1);
            end
            ST_CMD8: begin
              if (r1[2]) begin
                v2_d    = 1'b0;
                state_d = ST_CMD55;
              end else if (r1 == 8'h01 && bus.resp[11:0] == 12'h1AA) begin
                v2_d    = 1'b1;
                state_d = ST_CMD55;
              end else begin
                fail = 1'b1; fail_code = 3'd2;
              end
            end
            ST_CMD55: begin
              if (r1 == 8'h00 || r1 == 8'h01) state_d = ST_CMD41;
              else begin fail = 1'b1; fail_code = 3'd3; end
            end
            ST_CMD41: begin
              if (r1 == 8'h00) begin
                if (v2_q) state_d = ST_CMD58;
                else begin sdhc_d = 1'b0; finish_ok = 1'b1; end
              end else if (r1 == 8'h01) begin
                if (pair_q == AW'(ACMD41_RETRIES - 1)) begin fail = 1'b1; fail_code = 3'd4; end
                else begin
                  pair_d  = pair_q + AW'(1);
                  state_d = ST_CMD55;
                end
              end else begin
                fail = 1'b1; fail_code = 3'd3;
              end
            end
            ST_CMD58: begin
              if (r1 == 8'h00) begin sdhc_d = bus.resp[30]; finish_ok = 1'b1; end
              else begin fail = 1'b1; fail_code = 3'd6; end
            end
            default: ;
          endcase
        end else if (tmo_q == TW'(CMD_TIMEOUT - 1)) begin
          fail = 1'b1; fail_code = 3'd5;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
    endcase

    if (fail) begin
      error_d    = 1'b1;
      err_code_d = fail_code;
      busy_d     = 1'b0;
      await_d    = 1'b0;
      state_d    = ST_ERROR;
    end
    if (finish_ok) begin
      ready_d = 1'b1;
      busy_d  = 1'b0;
      state_d = ST_DONE;
    end

    // Load the command fields together with the one-cycle start pulse.
    if (issue) begin
      start_d = 1'b1;
      await_d = 1'b1;
      tmo_d   = '0;
      case (issue_st)
        ST_CMD0:  begin cmd_d = 6'd0;  arg_d = 32'h0000_0000; crc_d = 7'h4A; nresp_d = 3'd1; end
        ST_CMD8:  begin cmd_d = 6'd8;  arg_d = 32'h0000_01AA; crc_d = 7'h43; nresp_d = 3'd5; end
        ST_CMD55: begin cmd_d = 6'd55; arg_d = 32'h0000_0000; crc_d = 7'h32; nresp_d = 3'd1; end
        ST_CMD41: begin
          cmd_d   = 6'd41;
          arg_d   = v2_q ? 32'h4000_0000 : 32'h0000_0000;
          crc_d   = v2_q ? 7'h3B : 7'h72;
          nresp_d = 3'd1;
        end
        ST_CMD58: begin cmd_d = 6'd58; arg_d = 32'h0000_0000; crc_d = 7'h7E; nresp_d = 3'd5; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      await_q    <= 1'b0;
      gap_q      <= '0;
      tmo_q      <= '0;
      c0_q       <= '0;
      pair_q     <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 3'd0;
      v2_q       <= 1'b0;
      sdhc_q     <= 1'b0;
      cmd_q      <= 6'd0;
      arg_q      <= 32'd0;
      crc_q      <= 7'd0;
      nresp_q    <= 3'd0;
      start_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      await_q    <= await_d;
      gap_q      <= gap_d;
      tmo_q      <= tmo_d;
      c0_q       <= c0_d;
      pair_q     <= pair_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      v2_q       <= v2_d;
      sdhc_q     <= sdhc_d;
      cmd_q      <= cmd_d;
      arg_q      <= arg_d;
      crc_q      <= crc_d;
      nresp_q    <= nresp_d;
      start_q    <= start_d;
    end
  end

  assign busy          = busy_q;
  assign ready         = ready_q;
  assign error         = error_q;
  assign err_code      = err_code_q;
  assign card_v2       = v2_q;
  assign card_sdhc     = sdhc_q;
  assign bus.cmd       = cmd_q;
  assign bus.arg       = arg_q;
  assign bus.crc       = crc_q;
  assign bus.nresponse = nresp_q;
  assign bus.cmd_start = start_q;

endmodule

// File: tb/tb_sd_init_sequencer.sv
// Directed bench for sd_init_sequencer with a behavioural card responder
// that logs every issued command, its gap and its handshake behaviour.
module tb_sd_init_sequencer;

  localparam int unsigned GAP = 16;

  logic       clk;
  logic       rst;
  logic       init_start;
  logic       busy, ready, error, card_v2, card_sdhc;
  logic [2:0] err_code;

  sd_init_sequencer_if bus ();

  sd_init_sequencer #(
    .CMD0_RETRIES  (8),
    .ACMD41_RETRIES(5),
    .GAP_CYCLES    (GAP),
    .CMD_TIMEOUT   (100)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .init_start(init_start),
    .busy      (busy),
    .ready     (ready),
    .error     (error),
    .err_code  (err_code),
    .card_v2   (card_v2),
    .card_sdhc (card_sdhc),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Responder configuration and observation state
  logic [7:0]  cmd0_r1, cmd8_r1;
  int          cmd41_ones, n41;
  bit          resp_en;
  logic [47:0] log_q[$];
  logic [47:0] held;
  bit          pending, have_done;
  int          lat, cyc, done_cyc, min_gap, max_gap, viol;

  function automatic logic [39:0] respond(logic [5:0] c);
    case (c)
      6'd0:  begin n41 = 0; return {cmd0_r1, 32'h0}; end
      6'd8:  return {cmd8_r1, (cmd8_r1 == 8'h01) ? 32'h0000_01AA : 32'h0};
      6'd55: return {8'h01, 32'h0};
      6'd41: begin
        if (n41 < cmd41_ones) begin n41++; return {8'h01, 32'h0}; end
        return {8'h00, 32'h0};
      end
      6'd58: return {8'h00, 32'hC0FF_8000};
      default: return {8'hFF, 32'h0};
    endcase
  endfunction

  function automatic logic [41:0] exp_fields(logic [5:0] c, logic v2);
    case (c)
      6'd0:  return {32'h0000_0000, 7'h4A, 3'd1};
      6'd8:  return {32'h0000_01AA, 7'h43, 3'd5};
      6'd55: return {32'h0000_0000, 7'h32, 3'd1};
      6'd41: return v2 ? {32'h4000_0000, 7'h3B, 3'd1} : {32'h0000_0000, 7'h72, 3'd1};
      6'd58: return {32'h0000_0000, 7'h7E, 3'd5};
      default: return 42'h0;
    endcase
  endfunction

  // Card model: answers each command after a fixed latency, sampled on negedge.
  initial begin
    bus.cmd_done = 1'b0;
    bus.resp     = 40'h0;
    pending = 0; have_done = 0; cyc = 0; n41 = 0;
    forever begin
      @(negedge clk);
      cyc++;
      bus.cmd_done = 1'b0;
      if (rst) begin pending = 0; continue; end
      if (pending && {bus.cmd, bus.arg, bus.crc, bus.nresponse} !== held) viol++;
      if (bus.cmd_start) begin
        if (pending) viol++;
        held = {bus.cmd, bus.arg, bus.crc, bus.nresponse};
        log_q.push_back(held);
        if (have_done) begin
          if (cyc - done_cyc < min_gap) min_gap = cyc - done_cyc;
          if (cyc - done_cyc > max_gap) max_gap = cyc - done_cyc;
        end
        pending = 1;
        lat = 3;
      end else if (pending && resp_en) begin
        lat--;
        if (lat == 0) begin
          bus.resp     = respond(held[47:42]);
          bus.cmd_done = 1'b1;
          pending      = 0;
          done_cyc     = cyc;
          have_done    = 1;
        end
      end
    end
  end

  task automatic clear_log();
    log_q.delete();
    have_done = 0;
    min_gap   = 1000000;
    max_gap   = 0;
    viol      = 0;
  endtask

  task automatic start_init();
    @(negedge clk) init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
  endtask

  task automatic wait_end(output bit ok);
    ok = 0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      if (ready || error) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ready, error, err_code, card_v2, card_sdhc} !== 8'h00) begin
      failures++; $display("FAIL reset_status: got %b expected 0", {busy, ready, error, err_code, card_v2, card_sdhc});
    end
    checks++;
    if ({bus.cmd, bus.arg, bus.crc, bus.nresponse, bus.cmd_start} !== 49'h0) begin
      failures++; $display("FAIL reset_bus: got %h expected 0", {bus.cmd, bus.arg, bus.crc, bus.nresponse, bus.cmd_start});
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if ({busy, ready, error, bus.cmd_start} !== 4'b0000 || log_q.size() != 0) begin
      failures++; $display("FAIL idle_after_reset: got %b/%0d expected 0/0", {busy, ready, error, bus.cmd_start}, log_q.size());
    end
  endtask

  task automatic test_v2_sdhc();
    logic [5:0] exp_q[$];
    bit ok;
    cmd0_r1 = 8'h01; cmd8_r1 = 8'h01; cmd41_ones = 3; resp_en = 1;
    clear_log();
    start_init();
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL v2_busy: got %b expected 1", busy); end
    wait_end(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL v2_complete: got timeout expected ready/error"); end
    checks++;
    if ({ready, error, card_v2, card_sdhc, busy} !== 5'b10110) begin
      failures++; $display("FAIL v2_status: got %b expected 10110", {ready, error, card_v2, card_sdhc, busy});
    end
    exp_q = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd58};
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL v2_cmd_count: got %0d expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== {exp_q[i], exp_fields(exp_q[i], 1'b1)}) begin
        failures++; $display("FAIL v2_cmd[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 48'h0, {exp_q[i], exp_fields(exp_q[i], 1'b1)});
      end
    end
    checks++;
    if (min_gap != GAP + 1 || max_gap != GAP + 1) begin
      failures++; $display("FAIL v2_gap: got min %0d max %0d expected %0d", min_gap, max_gap, GAP + 1);
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL v2_handshake: got %0d violations expected 0", viol); end
  endtask

  task automatic test_v1_busy_ignore();
    logic [5:0] exp_q[$];
    bit ok, seen;
    cmd8_r1 = 8'h05; cmd41_ones = 0;
    clear_log();
    start_init();
    checks++;
    if ({ready, busy} !== 2'b01) begin failures++; $display("FAIL v1_ready_cleared: got %b expected 01", {ready, busy}); end
    for (int i = 0; i < 200 && log_q.size() < 2; i++) @(negedge clk);
    start_init();
    // Pulse init_start in the very cycle the DUT samples cmd_done.
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (bus.cmd_done) begin seen = 1; break; end
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL v1_done_seen: got none expected cmd_done"); end
    init_start = 1'b1;
    @(negedge clk) init_start = 1'b0;
    wait_end(ok);
    checks++;
    if (!ok || {ready, error, card_v2, card_sdhc, busy} !== 5'b10000) begin
      failures++; $display("FAIL v1_status: got %b expected 10000", {ready, error, card_v2, card_sdhc, busy});
    end
    exp_q = '{6'd0, 6'd8, 6'd55, 6'd41};
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL v1_cmd_count: got %0d expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== {exp_q[i], exp_fields(exp_q[i], 1'b0)}) begin
        failures++; $display("FAIL v1_cmd[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 48'h0, {exp_q[i], exp_fields(exp_q[i], 1'b0)});
      end
    end
  endtask

  task automatic test_cmd0_fail();
    bit ok;
    int n_other;
    cmd0_r1 = 8'hFF;
    clear_log();
    start_init();
    wait_end(ok);
    checks++;
    if (!ok || {ready, error, err_code, busy} !== 6'b010010) begin
      failures++; $display("FAIL cmd0_fail_status: got %b expected 010010", {ready, error, err_code, busy});
    end
    checks++;
    if (log_q.size() != 8) begin failures++; $display("FAIL cmd0_count: got %0d expected 8", log_q.size()); end
    n_other = 0;
    foreach (log_q[i]) if (log_q[i] !== {6'd0, exp_fields(6'd0, 1'b0)}) n_other++;
    checks++;
    if (n_other != 0) begin failures++; $display("FAIL cmd0_only: got %0d other commands expected 0", n_other); end
  endtask

  task automatic test_acmd41_limit();
    logic [5:0] exp_q[$];
    bit ok;
    cmd0_r1 = 8'h01; cmd8_r1 = 8'h01; cmd41_ones = 1000;
    clear_log();
    start_init();
    wait_end(ok);
    checks++;
    if (!ok || {ready, error, err_code, busy} !== 6'b011000) begin
      failures++; $display("FAIL acmd41_limit_status: got %b expected 011000", {ready, error, err_code, busy});
    end
    exp_q = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41};
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL acmd41_count: got %0d expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== {exp_q[i], exp_fields(exp_q[i], 1'b1)}) begin
        failures++; $display("FAIL acmd41_cmd[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 48'h0, {exp_q[i], exp_fields(exp_q[i], 1'b1)});
      end
    end
  endtask

  task automatic test_timeout();
    resp_en = 0;
    clear_log();
    start_init();
    checks++;
    if (bus.cmd_start !== 1'b1 || bus.cmd !== 6'd0) begin
      failures++; $display("FAIL timeout_issue: got start %b cmd %0d expected 1/0", bus.cmd_start, bus.cmd);
    end
    repeat (99) @(negedge clk);
    checks++;
    if ({error, busy} !== 2'b01) begin failures++; $display("FAIL timeout_early: got %b expected 01", {error, busy}); end
    @(negedge clk);
    checks++;
    if ({error, err_code, busy} !== 5'b11010) begin
      failures++; $display("FAIL timeout_fire: got %b expected 11010", {error, err_code, busy});
    end
    checks++;
    if (log_q.size() != 1) begin failures++; $display("FAIL timeout_single_cmd: got %0d expected 1", log_q.size()); end
    resp_en = 1;
  endtask

  task automatic test_rst_restart();
    logic [5:0] exp_q[$];
    bit ok;
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
    cmd0_r1 = 8'h01; cmd8_r1 = 8'h01; cmd41_ones = 3;
    clear_log();
    start_init();
    ok = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk); #1;
      if (log_q.size() >= 5) begin ok = 1; break; end
    end
    checks++;
    if (!ok || bus.cmd_start !== 1'b1) begin
      failures++; $display("FAIL rst_mid_loop: got %0d cmds start %b expected 5/1", log_q.size(), bus.cmd_start);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({busy, ready, error, err_code, card_v2, card_sdhc, bus.cmd, bus.arg, bus.crc, bus.nresponse, bus.cmd_start} !== 57'h0) begin
      failures++; $display("FAIL rst_async_clear: got %h expected 0", {busy, ready, error, err_code, card_v2, card_sdhc, bus.cmd, bus.arg, bus.crc, bus.nresponse, bus.cmd_start});
    end
    @(negedge clk); #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, ready, error, card_v2, bus.cmd_start} !== 5'b00000) begin
      failures++; $display("FAIL rst_stay_idle: got %b expected 00000", {busy, ready, error, card_v2, bus.cmd_start});
    end
    clear_log();
    start_init();
    wait_end(ok);
    checks++;
    if (!ok || {ready, error, card_v2, card_sdhc, busy} !== 5'b10110) begin
      failures++; $display("FAIL restart_status: got %b expected 10110", {ready, error, card_v2, card_sdhc, busy});
    end
    exp_q = '{6'd0, 6'd8, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd55, 6'd41, 6'd58};
    checks++;
    if (log_q.size() != exp_q.size()) begin
      failures++; $display("FAIL restart_cmd_count: got %0d expected %0d", log_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (i >= log_q.size() || log_q[i] !== {exp_q[i], exp_fields(exp_q[i], 1'b1)}) begin
        failures++; $display("FAIL restart_cmd[%0d]: got %h expected %h", i, (i < log_q.size()) ? log_q[i] : 48'h0, {exp_q[i], exp_fields(exp_q[i], 1'b1)});
      end
    end
    checks++;
    if (viol != 0) begin failures++; $display("FAIL restart_handshake: got %0d violations expected 0", viol); end
  endtask

  initial begin
    rst        = 1'b1;
    init_start = 1'b0;
    cmd0_r1    = 8'h01;
    cmd8_r1    = 8'h01;
    cmd41_ones = 0;
    resp_en    = 1;
    clear_log();
    test_reset();
    test_v2_sdhc();
    test_v1_busy_ignore();
    test_cmd0_fail();
    test_acmd41_limit();
    test_timeout();
    test_rst_restart();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_init_sequencer.md
Name: sd_init_sequencer

Overview:
- Drives `sd_controller` through the SPI-mode SD card power-up sequence: CMD0, CMD8, repeated CMD55/ACMD41, then CMD58.
- Reports card version, capacity class, ready and error status to the system.
- Sits between the system/host and the `sd_controller` command interface (cmd, arg, crc, nresponse, start, done).
- Is the sole issuer of commands to `sd_controller` until ready or error.

Parameters:
- CMD0_RETRIES, 8: max CMD0 attempts before error.
- ACMD41_RETRIES, 1000: max CMD55+ACMD41 pairs before error.
- GAP_CYCLES, 16: idle clk cycles between command completion and next `cmd_start`.
- CMD_TIMEOUT, 65535: clk cycles allowed from `cmd_start` to `cmd_done`.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- init_start  in  1  one-cycle pulse; begins the sequence.
- busy  out  1  high while the sequence is running.
- ready  out  1  high after a successful init; held until the next `init_start` or `rst`.
- error  out  1  high after a failed init; held until the next `init_start` or `rst`.
- err_code  out  3  failure cause, valid while `error`=1.
- card_v2  out  1  card accepted CMD8 (SD v2+).
- card_sdhc  out  1  OCR CCS bit (bit 30) from CMD58.
- cmd  out  6  command index to `sd_controller`.
- arg  out  32  command argument.
- crc  out  7  CRC7 (without end bit).
- nresponse  out  3  response bytes expected (1 or 5).
- cmd_start  out  1  one-cycle pulse issuing a command.
- cmd_done  in  1  one-cycle pulse; command finished.
- resp  in  40  response; [39:32]=R1, [31:0]=trailing bytes; valid in the `cmd_done` cycle.

Behaviour:
- Reset values:
  - All outputs 0.
  - Internal state: IDLE.
- Command issue handshake:
  - Load cmd/arg/crc/nresponse.
  - Pulse `cmd_start` for exactly 1 cycle.
  - Hold cmd/arg/crc/nresponse stable until `cmd_done`.
  - Never issue a new `cmd_start` before `cmd_done` is seen.
- Command timeout:
  - A 16-bit timeout counter starts at `cmd_start`.
  - Reaching CMD_TIMEOUT without `cmd_done` -> ERROR, err_code=5.
- Inter-command gap:
  - After each `cmd_done`, wait GAP_CYCLES cycles (WAIT state) before the next command.
  - A `cmd_start` may therefore follow `cmd_done` no sooner than GAP_CYCLES+1 cycles later.
- Command set:
  - CMD0: arg 0x00000000, crc 0x4A, nresponse 1.
  - CMD8: arg 0x000001AA, crc 0x43, nresponse 5.
  - CMD55: arg 0, crc 0x32, nresponse 1.
  - CMD41: arg 0x40000000 if card_v2 else 0x00000000; crc 0x3B if card_v2 else 0x72; nresponse 1.
  - CMD58: arg 0, crc 0x7E, nresponse 5.
- States:
  - IDLE: on `init_start` -> clear ready, error, card_v2, card_sdhc and all retry counters; set busy; -> CMD0.
  - CMD0:
    - R1==0x01 -> CMD8.
    - Otherwise retry.
    - After CMD0_RETRIES failed attempts -> ERROR, err_code=1.
  - CMD8:
    - R1 bit2 (illegal command) set -> card_v2=0 -> CMD55.
    - Else R1==0x01 and resp[11:0]==0x1AA -> card_v2=1 -> CMD55.
    - Else -> ERROR, err_code=2.
  - CMD55:
    - R1 in {0x00, 0x01} -> CMD41.
    - Else -> ERROR, err_code=3.
  - CMD41:
    - R1==0x00 -> CMD58 if card_v2, else DONE with card_sdhc=0.
    - R1==0x01 -> increment pair counter; at ACMD41_RETRIES -> ERROR, err_code=4; else -> CMD55.
    - Any other R1 -> ERROR, err_code=3.
  - CMD58:
    - R1==0x00 -> card_sdhc=resp[30] -> DONE.
    - Else -> ERROR, err_code=6.
  - DONE: busy=0, ready=1 -> IDLE (ready held).
  - ERROR: busy=0, error=1 -> IDLE (error and err_code held).
- `init_start` while busy is ignored.
- `init_start` in the same cycle as `cmd_done` while busy is ignored; `cmd_done` is processed.
- `cmd_done` while not awaiting a response is ignored.
- `rst` mid-sequence:
  - Immediately returns to the reset values.
  - `cmd_start` drops combinationally with the asynchronous reset.
  - Any in-flight `sd_controller` command is abandoned.
  - The next `init_start` restarts from CMD0.
- err_code values:
  - 1: CMD0 retry limit reached.
  - 2: bad CMD8 response.
  - 3: bad R1 in CMD55 or ACMD41.
  - 4: ACMD41 retry limit reached.
  - 5: command timeout.
  - 6: CMD58 R1 error.

Test Plan:
- v2 SDHC card: responder returns 0x01 to CMD0; 0x01+0x000001AA to CMD8; 0x01 to CMD55; 0x01 to ACMD41 ×3 then 0x00; 0x00+0xC0FF8000 to CMD58 -> ready=1, card_v2=1, card_sdhc=1, error=0. Check 4 CMD55/CMD41 pairs, CMD41 arg 0x40000000, crc 0x3B, exact cmd/arg/crc per command, and gap ≥ GAP_CYCLES between commands.
- v1 card: CMD8 returns R1=0x05 -> CMD41 arg 0, crc 0x72; on R1 0x00 -> ready=1, card_v2=0, card_sdhc=0, and no CMD58 issued.
- CMD0 failure: responder always returns 0xFF -> exactly 8 CMD0 issued, then error=1, err_code=1, busy=0.
- ACMD41 timeout with ACMD41_RETRIES=5 and ACMD41 always 0x01 -> 5 pairs issued, then err_code=4.
- No `cmd_done` with CMD_TIMEOUT=100 -> error with err_code=5 exactly 100 cycles after `cmd_start`.
- Reset and restart:
  - Assert `rst` for 1 cycle mid-ACMD41 loop -> all outputs 0 immediately.
  - Then `init_start` -> sequence restarts at CMD0 and completes normally.
  - `init_start` pulsed while busy -> no effect on command stream.
